dpram_fifo_ctrl: RTL and testbench

Sequencing controller that turns one inferable asynchronous-read dual-port RAM (one write port, one combinational read port) into a first-word-fall-through FIFO with valid/ready handshakes on both sides. The block owns the write and read pointers, the fill count and the full/empty state, and drives the RAM's write and read ports directly. The RAM sits outside the block; the integrator connects the RamXxx ports one-to-one to the RAM. It is used for stream buffering between FPGA-mapped IP blocks.

---
 rtl/dpram_fifo_ctrl.sv | 147 ++++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external async-read dual-port RAM.
// Optional sticky Overflow_SO/Underflow_SO outputs are built when DPRAM_FIFO_ERRFLAGS_EN is defined.
module dpram_fifo_ctrl #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_DEPTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int ALMOST_FULL_TH = 12
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    input  logic                  Clear_SI,
    input  logic                  In_Valid_SI,
    output logic                  In_Ready_SO,
    input  logic [DATA_WIDTH-1:0] In_Data_DI,
    output logic                  Out_Valid_SO,
    input  logic                  Out_Ready_SI,
    output logic [DATA_WIDTH-1:0] Out_Data_DO,
    output logic [ADDR_WIDTH:0]   Fill_SO,
    output logic                  AlmostFull_SO,
`ifdef DPRAM_FIFO_ERRFLAGS_EN
    output logic                  Overflow_SO,
    output logic                  Underflow_SO,
`endif
    output logic                  RamWrEn_SO,
    output logic [ADDR_WIDTH-1:0] RamWrAddr_DO,
    output logic [DATA_WIDTH-1:0] RamWrData_DO,
    output logic [ADDR_WIDTH-1:0] RamRdAddr_DO,
    input  logic [DATA_WIDTH-1:0] RamRdData_DI
);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_CNT    = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  in_ready;
    logic                  out_valid;
    logic                  push;
    logic                  pop;

    // Handshakes; reset gating keeps the RAM write port quiet while Rst_RI is high.
    assign push = In_Valid_SI & in_ready & ~Clear_SI & ~Rst_RI;
    assign pop  = Out_Valid_SO & Out_Ready_SI & ~Clear_SI & ~Rst_RI;

    always_comb begin
        count_next = count;
        if (Clear_SI)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (Clear_SI) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI)
            state <= EMPTY;
        else
            state <= next_state;
    end

    // State tracks the next count so it always agrees with the fill level.
    always_comb begin
        next_state = PARTIAL;
        if (count_next == '0)
            next_state = EMPTY;
        else if (count_next == DEPTH_CNT)
            next_state = FULL;
    end

    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
    end

    assign In_Ready_SO   = in_ready;
    assign Out_Valid_SO  = out_valid;
    assign Fill_SO       = count;
    assign AlmostFull_SO = (count >= AF_CNT);
    assign RamWrEn_SO    = push;
    assign RamWrAddr_DO  = wr_ptr;
    assign RamWrData_DO  = In_Data_DI;
    assign RamRdAddr_DO  = rd_ptr;
    assign Out_Data_DO   = RamRdData_DI;

`ifdef DPRAM_FIFO_ERRFLAGS_EN
    logic overflow;
    logic underflow;

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (Clear_SI) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (In_Valid_SI && state == FULL)
                overflow <= 1'b1;
            if (Out_Ready_SI && state == EMPTY)
                underflow <= 1'b1;
        end
    end

    assign Overflow_SO  = overflow;
    assign Underflow_SO = underflow;
`endif

`ifndef SYNTHESIS
    always @(posedge Clk_CI) begin
        if (!Rst_RI) begin
            assert (DATA_DEPTH >= 2 && DATA_DEPTH <= (1 << ADDR_WIDTH))
                else $error("dpram_fifo_ctrl: DATA_DEPTH out of range");
            assert (ALMOST_FULL_TH >= 1 && ALMOST_FULL_TH <= DATA_DEPTH)
                else $error("dpram_fifo_ctrl: ALMOST_FULL_TH out of range");
            assert (count <= DEPTH_CNT)
                else $error("dpram_fifo_ctrl: count exceeds DATA_DEPTH");
        end
    end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl: a depth-16 instance for the main checks and a depth-12
// instance for non-power-of-two pointer wrap. Flag checks are built with DPRAM_FIFO_ERRFLAGS_EN.
module tb_dpram_fifo_ctrl;

    logic clk;
    logic rst;
    int   checkCount;
    int   errCount;

    // Depth-16 instance signals
    logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_almost_full;
    logic [31:0] a_in_data, a_out_data, a_wr_data, a_rd_data;
    logic [4:0]  a_fill;
    logic        a_wr_en;
    logic [3:0]  a_wr_addr, a_rd_addr;
    logic        a_ovf, a_unf;
    logic [31:0] memA [16];

    // Depth-12 instance signals
    logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_almost_full;
    logic [31:0] b_in_data, b_out_data, b_wr_data, b_rd_data;
    logic [4:0]  b_fill;
    logic        b_wr_en;
    logic [3:0]  b_wr_addr, b_rd_addr;
    logic        b_ovf, b_unf;
    logic [31:0] memB [16];

    // Reference model state
    int          mA_count, mA_wr, mA_rd;
    logic        mA_ovf, mA_unf;
    logic [31:0] sbA [$];
    int          mB_count, mB_wr, mB_rd;
    logic [31:0] sbB [$];

    dpram_fifo_ctrl dutA (
        .Clk_CI(clk), .Rst_RI(rst), .Clear_SI(a_clear),
        .In_Valid_SI(a_in_valid), .In_Ready_SO(a_in_ready), .In_Data_DI(a_in_data),
        .Out_Valid_SO(a_out_valid), .Out_Ready_SI(a_out_ready), .Out_Data_DO(a_out_data),
        .Fill_SO(a_fill), .AlmostFull_SO(a_almost_full),
`ifdef DPRAM_FIFO_ERRFLAGS_EN
        .Overflow_SO(a_ovf), .Underflow_SO(a_unf),
`endif
        .RamWrEn_SO(a_wr_en), .RamWrAddr_DO(a_wr_addr), .RamWrData_DO(a_wr_data),
        .RamRdAddr_DO(a_rd_addr), .RamRdData_DI(a_rd_data)
    );

    dpram_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_DEPTH(12), .DATA_WIDTH(32), .ALMOST_FULL_TH(9)) dutB (
        .Clk_CI(clk), .Rst_RI(rst), .Clear_SI(b_clear),
        .In_Valid_SI(b_in_valid), .In_Ready_SO(b_in_ready), .In_Data_DI(b_in_data),
        .Out_Valid_SO(b_out_valid), .Out_Ready_SI(b_out_ready), .Out_Data_DO(b_out_data),
        .Fill_SO(b_fill), .AlmostFull_SO(b_almost_full),
`ifdef DPRAM_FIFO_ERRFLAGS_EN
        .Overflow_SO(b_ovf), .Underflow_SO(b_unf),
`endif
        .RamWrEn_SO(b_wr_en), .RamWrAddr_DO(b_wr_addr), .RamWrData_DO(b_wr_data),
        .RamRdAddr_DO(b_rd_addr), .RamRdData_DI(b_rd_data)
    );

    always @(posedge clk) begin
        if (a_wr_en) memA[a_wr_addr] <= a_wr_data;
        if (b_wr_en) memB[b_wr_addr] <= b_wr_data;
    end
    assign a_rd_data = memA[a_rd_addr];
    assign b_rd_data = memB[b_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic resetModelA();
        mA_count = 0; mA_wr = 0; mA_rd = 0;
        mA_ovf = 1'b0; mA_unf = 1'b0;
        sbA.delete();
    endtask

    // One cycle on the depth-16 instance: drive, check at negedge, advance the model, clock.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic clr);
        logic expPush, expPop;
        a_in_valid = v; a_in_data = d; a_out_ready = r; a_clear = clr;
        @(negedge clk);
        expPush = v && (mA_count != 16) && !clr;
        expPop  = (mA_count != 0) && r && !clr;
        checkOutput("inReady", a_in_ready, mA_count != 16);
        checkOutput("outValid", a_out_valid, mA_count != 0);
        checkOutput("fill", a_fill, mA_count);
        checkOutput("almostFull", a_almost_full, mA_count >= 12);
        checkOutput("ramWrEn", a_wr_en, expPush);
        checkOutput("ramWrAddr", a_wr_addr, mA_wr);
        checkOutput("ramRdAddr", a_rd_addr, mA_rd);
        if (expPush) checkOutput("ramWrData", a_wr_data, d);
        if (mA_count != 0) checkOutput("outData", a_out_data, sbA[0]);
`ifdef DPRAM_FIFO_ERRFLAGS_EN
        checkOutput("overflow", a_ovf, mA_ovf);
        checkOutput("underflow", a_unf, mA_unf);
`endif
        if (clr) begin
            mA_count = 0; mA_wr = 0; mA_rd = 0;
            mA_ovf = 1'b0; mA_unf = 1'b0;
            sbA.delete();
        end else begin
            if (v && mA_count == 16) mA_ovf = 1'b1;
            if (r && mA_count == 0) mA_unf = 1'b1;
            if (expPush) begin
                sbA.push_back(d);
                mA_wr = (mA_wr == 15) ? 0 : mA_wr + 1;
                mA_count++;
            end
            if (expPop) begin
                void'(sbA.pop_front());
                mA_rd = (mA_rd == 15) ? 0 : mA_rd + 1;
                mA_count--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One cycle on the depth-12 instance; the write address must stay inside 0..11.
    task automatic applyStimulusB(input logic v, input logic [31:0] d, input logic r);
        logic expPush, expPop;
        b_in_valid = v; b_in_data = d; b_out_ready = r; b_clear = 1'b0;
        @(negedge clk);
        expPush = v && (mB_count != 12);
        expPop  = (mB_count != 0) && r;
        checkOutput("bInReady", b_in_ready, mB_count != 12);
        checkOutput("bFill", b_fill, mB_count);
        checkOutput("bAlmostFull", b_almost_full, mB_count >= 9);
        checkOutput("bRamWrAddr", b_wr_addr, mB_wr);
        checkOutput("bRamRdAddr", b_rd_addr, mB_rd);
        checkOutput("bWrAddrInRange", b_wr_addr <= 4'd11, 1'b1);
        if (mB_count != 0) checkOutput("bOutData", b_out_data, sbB[0]);
        if (expPush) begin
            sbB.push_back(d);
            mB_wr = (mB_wr == 11) ? 0 : mB_wr + 1;
            mB_count++;
        end
        if (expPop) begin
            void'(sbB.pop_front());
            mB_rd = (mB_rd == 11) ? 0 : mB_rd + 1;
            mB_count--;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0; errCount = 0;
        resetModelA();
        mB_count = 0; mB_wr = 0; mB_rd = 0;
        a_clear = 0; a_in_valid = 1; a_in_data = 32'hDEAD; a_out_ready = 1;
        b_clear = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstInReady", a_in_ready, 1'b1);
        checkOutput("rstOutValid", a_out_valid, 1'b0);
        checkOutput("rstFill", a_fill, 0);
        checkOutput("rstRamWrEn", a_wr_en, 1'b0);
        checkOutput("rstWrAddr", a_wr_addr, 0);
        checkOutput("rstRdAddr", a_rd_addr, 0);
        checkOutput("rstAlmostFull", a_almost_full, 1'b0);
        a_in_valid = 0; a_out_ready = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        $display("[TB] reset released");

        applyStimulus(0, 0, 0, 0);
        // Three back-to-back pushes, then drain and poke the empty side.
        applyStimulus(1, 32'h11, 0, 0);
        applyStimulus(1, 32'h22, 0, 0);
        applyStimulus(1, 32'h33, 0, 0);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);

        // Fill to capacity, push against full, then free one slot.
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) applyStimulus(1, i, 0, 0);
        applyStimulus(1, 32'hBAD, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 1, 0);

        // Clear at fill 7 with a concurrent push.
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) applyStimulus(1, 32'h700 + i, 0, 0);
        applyStimulus(1, 32'h7FF, 1, 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 32'hA5, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);

        for (int i = 0; i < 150; i++)
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 31) == 0));

        // Asynchronous reset in the middle of traffic discards everything.
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'hC0 + i, 0, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstFill", a_fill, 0);
        checkOutput("midRstOutValid", a_out_valid, 1'b0);
        checkOutput("midRstWrAddr", a_wr_addr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        resetModelA();
        applyStimulus(0, 0, 0, 0);

        // Depth-12 instance: preload 5, then 30 concurrent push/pop cycles across the wrap.
        for (int i = 0; i < 5; i++) applyStimulusB(1, 32'h100 + i, 0);
        for (int i = 0; i < 30; i++) applyStimulusB(1, 32'h200 + i, 1);
        for (int i = 0; i < 6; i++) applyStimulusB(0, 0, 1);
        for (int i = 0; i < 13; i++) applyStimulusB(1, 32'h300 + i, 0);
        for (int i = 0; i < 13; i++) applyStimulusB(0, 0, 1);

        $display("test done: total=%0d bad=%0d", checkCount, errCount);
        $finish;
    end

endmodule
